waveform_buffer_reader: RTL and testbench
=========================================

# waveform_buffer_reader

Read-side engine for the mDOM waveform buffer storage. It pops one header per stored waveform from the header FIFO, then fetches the waveform's 85-bit buffer lines and unpacks each into four 21-bit sample words, oldest first. Words go out on a valid/ready stream toward the readout formatter. A completion pulse carries the last line address so the write side can reclaim buffer space.

## Interface
Parameters:
- P_DATA_WIDTH, 85, buffer line width: 4 words plus 1 EOE bit
- P_WORD_WIDTH, 21, sample word width
- P_ADR_WIDTH, 10, buffer line address width
- P_HDR_WIDTH, 104, header width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- hdr_empty  in  1  header FIFO empty
- hdr_data  in  P_HDR_WIDTH  header FIFO output; valid the cycle after hdr_rdreq
- hdr_rdreq  out  1  header FIFO pop, one-cycle pulse
- wvb_rd_addr  out  P_ADR_WIDTH  buffer read address
- wvb_data  in  P_DATA_WIDTH  buffer read data; valid 1 cycle after address
- out_hdr  out  P_HDR_WIDTH  header of the waveform being streamed; held until done
- out_data  out  P_WORD_WIDTH  sample word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_sop  out  1  first word of waveform
- out_eop  out  1  last word of waveform
- rd_done  out  1  one-cycle pulse when the last word is accepted
- rd_done_addr  out  P_ADR_WIDTH  stop address, valid with rd_done
- eoe_err  out  1  sticky EOE mismatch flag

## Operation
- Header fields:
  - hdr_data[P_ADR_WIDTH-1:0] is the start line.
  - hdr_data[2*P_ADR_WIDTH-1:P_ADR_WIDTH] is the stop line, inclusive.
  - The remaining bits are opaque and pass through on out_hdr.
- Line unpack order, oldest to newest:
  - [21:1]
  - [42:22]
  - [63:43]
  - [84:64]
  - Bit [0] is EOE.
- FSM states:
  - IDLE: if !hdr_empty, assert hdr_rdreq and go to POP.
  - POP: wait for FIFO data, then go to LATCH.
  - LATCH: register hdr_data into out_hdr, set addr to start, set first-flag, go to FETCH.
  - FETCH: drive wvb_rd_addr, go to WAIT.
  - WAIT: load line register from wvb_data, word index = 0, go to EMIT.
  - EMIT: out_valid = 1. On each accept (out_valid && out_ready), increment the index.
    - On the 4th accept, if addr == stop, pulse rd_done and go to IDLE.
    - Otherwise addr = addr + 1 modulo 2^P_ADR_WIDTH, go to FETCH.
- out_sop is high only for word 0 of the first line.
- out_eop is high only for word 3 of the stop line.
- Start == stop gives a single line (4 words).
- Address wraps from 2^P_ADR_WIDTH−1 to 0.
- out_data, out_sop and out_eop are stable while out_valid && !out_ready.
- hdr_rdreq is never asserted while hdr_empty is high, nor outside IDLE.

## Timing
- Reset values:
  - hdr_rdreq = 0, wvb_rd_addr = 0
  - out_hdr = 0, out_data = 0
  - out_valid = 0, out_sop = 0, out_eop = 0
  - rd_done = 0, rd_done_addr = 0, eoe_err = 0
  - FSM = IDLE
- Reset mid-waveform aborts immediately:
  - No rd_done is issued.
  - The popped header is lost. The write side is reset together with the reader.
- Latency, hdr_empty falling (IDLE) to first out_valid: 5 cycles (IDLE→POP→LATCH→FETCH→WAIT→EMIT).
- Line-to-line gap: 2 idle cycles (FETCH, WAIT) between word 3 and the next word 0.
- With out_ready held high, N lines take 6N cycles.
- rd_done is asserted in the cycle after the final accept, together with the return to IDLE.
- The next header pop can occur in that same IDLE cycle.
- The FIFO becoming non-empty during streaming has no effect until IDLE.

## Configuration
- WVB_READER_EOE_CHECK_EN:
  - Defined: in WAIT, compare the loaded line's EOE bit against (addr == stop). A mismatch sets eoe_err, which stays set until reset. Streaming is unaffected.
  - Undefined: eoe_err is tied to 0 and no compare logic is built.

## Test plan
- Single header, start=5, stop=6, lines with distinct words, out_ready=1:
  - 8 words, oldest first, in 12 EMIT/fetch cycles.
  - out_sop on word 0, out_eop on word 7.
  - rd_done with rd_done_addr=6.
- Wrap: start=1022, stop=1:
  - Addresses 1022, 1023, 0, 1 are fetched, 16 words.
  - rd_done_addr=1.
- Backpressure: toggle out_ready pseudo-randomly.
  - Words are never dropped or duplicated.
  - Data is held stable while stalled.
  - Word count = 4×lines.
- Back-to-back: 3 headers queued (start==stop each).
  - 3 SOP/EOP pairs and 3 rd_done pulses.
  - hdr_rdreq pulses exactly 3 times.
  - hdr_rdreq never fires while hdr_empty=1.
- EOE check (macro defined): stop line with EOE=0 → eoe_err=1 and stays set. Same stimulus without the macro → eoe_err=0.
- Reset mid-EMIT: assert rst_n=0 at word 2.
  - All outputs go to 0 asynchronously and no rd_done follows.
  - After release, the next header streams normally.

Source files
------------

// File: rtl/waveform_buffer_reader.sv
// Read-side engine for the waveform buffer. It pops headers, fetches buffer lines and streams 21-bit words.
// Optional build macro WVB_READER_EOE_CHECK_EN adds a sticky EOE consistency check (eoe_err).
module waveform_buffer_reader #(
  parameter int P_DATA_WIDTH = 85,
  parameter int P_WORD_WIDTH = 21,
  parameter int P_ADR_WIDTH  = 10,
  parameter int P_HDR_WIDTH  = 104
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic [P_HDR_WIDTH-1:0]  out_hdr,
  output logic [P_WORD_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic                    rd_done,
  output logic [P_ADR_WIDTH-1:0]  rd_done_addr,
  output logic                    eoe_err
);

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned REST_W     = (LINE_WORDS - 1) * P_WORD_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LATCH = 3'd2,
    S_FETCH = 3'd3,
    S_WAIT  = 3'd4,
    S_EMIT  = 3'd5
  } state_t;

  state_t                  state_q;
  state_t                  state_next;
  logic [P_ADR_WIDTH-1:0]  addr_q;
  logic [P_ADR_WIDTH-1:0]  stop_addr;
  logic [REST_W-1:0]       rest_q;
  logic [1:0]              idx_q;
  logic                    first_q;
  logic                    accept;
  logic                    last_word;
  logic                    at_stop;

  assign stop_addr   = out_hdr[2*P_ADR_WIDTH-1:P_ADR_WIDTH];
  assign wvb_rd_addr = addr_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE:  if (!hdr_empty) state_next = S_POP;
      S_POP:   state_next = S_LATCH;
      S_LATCH: state_next = S_FETCH;
      S_FETCH: state_next = S_WAIT;
      S_WAIT:  state_next = S_EMIT;
      S_EMIT: begin
        if (accept && last_word) state_next = at_stop ? S_IDLE : S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Decoded controls; the pop request is held off while reset is asserted
  always_comb begin
    hdr_rdreq = 1'b0;
    accept    = 1'b0;
    last_word = (idx_q == 2'd3);
    at_stop   = (addr_q == stop_addr);
    if (state_q == S_IDLE) hdr_rdreq = rst_n && !hdr_empty;
    if (state_q == S_EMIT) accept = out_valid && out_ready;
  end

  // Datapath: header latch, line unpack and stream handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      rest_q       <= '0;
      idx_q        <= '0;
      first_q      <= 1'b0;
      out_hdr      <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      rd_done      <= 1'b0;
      rd_done_addr <= '0;
    end else begin
      rd_done <= 1'b0;
      case (state_q)
        S_LATCH: begin
          out_hdr <= hdr_data;
          addr_q  <= hdr_data[P_ADR_WIDTH-1:0];
          first_q <= 1'b1;
        end
        S_WAIT: begin
          out_data  <= wvb_data[P_WORD_WIDTH:1];
          rest_q    <= wvb_data[P_DATA_WIDTH-1:P_WORD_WIDTH+1];
          idx_q     <= 2'd0;
          out_valid <= 1'b1;
          out_sop   <= first_q;
          out_eop   <= 1'b0;
          first_q   <= 1'b0;
        end
        S_EMIT: begin
          if (accept) begin
            idx_q   <= 2'(idx_q + 2'd1);
            out_sop <= 1'b0;
            if (last_word) begin
              out_valid <= 1'b0;
              out_eop   <= 1'b0;
              if (at_stop) begin
                rd_done      <= 1'b1;
                rd_done_addr <= addr_q;
              end else begin
                addr_q <= P_ADR_WIDTH'(addr_q + P_ADR_WIDTH'(1));
              end
            end else begin
              out_data <= rest_q[P_WORD_WIDTH-1:0];
              rest_q   <= rest_q >> P_WORD_WIDTH;
              out_eop  <= at_stop && (idx_q == 2'd2);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WVB_READER_EOE_CHECK_EN
  // EOE must be set exactly on the stop line; a mismatch latches until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoe_err <= 1'b0;
    end else if ((state_q == S_WAIT) && (wvb_data[0] != at_stop)) begin
      eoe_err <= 1'b1;
    end
  end
`else
  logic unused_eoe;
  assign unused_eoe = wvb_data[0];
  assign eoe_err    = 1'b0;
`endif

endmodule

// File: tb/tb_waveform_buffer_reader.sv
// Scoreboard bench for waveform_buffer_reader: FIFO/RAM models, directed headers, decoupled monitor.
module tb_waveform_buffer_reader;

  localparam int DW = 85;
  localparam int WW = 21;
  localparam int AW = 10;
  localparam int HW = 104;
`ifdef WVB_READER_EOE_CHECK_EN
  localparam logic EOE_EXP = 1'b1;
`else
  localparam logic EOE_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hdr_empty;
  logic [HW-1:0] hdr_data = '0;
  logic          hdr_rdreq;
  logic [AW-1:0] wvb_rd_addr;
  logic [DW-1:0] wvb_data = '0;
  logic [HW-1:0] out_hdr;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sop;
  logic          out_eop;
  logic          rd_done;
  logic [AW-1:0] rd_done_addr;
  logic          eoe_err;

  always #5 clk = ~clk;

  waveform_buffer_reader dut (
    .clk(clk), .rst_n(rst_n), .hdr_empty(hdr_empty), .hdr_data(hdr_data),
    .hdr_rdreq(hdr_rdreq), .wvb_rd_addr(wvb_rd_addr), .wvb_data(wvb_data),
    .out_hdr(out_hdr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .rd_done(rd_done), .rd_done_addr(rd_done_addr), .eoe_err(eoe_err)
  );

  // Header FIFO model: data appears the cycle after the pop
  logic [HW-1:0] hdr_mem [16];
  int unsigned   wr_ptr = 0;
  int unsigned   rd_ptr = 0;
  assign hdr_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (hdr_rdreq && !hdr_empty) begin
      hdr_data <= hdr_mem[rd_ptr[3:0]];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // Buffer RAM model: one-cycle read latency
  logic [DW-1:0] wmem [1024];
  always @(posedge clk) wvb_data <= wmem[wvb_rd_addr];

  // Downstream ready: constant or LFSR-driven backpressure
  logic        bp_mode = 1'b0;
  logic [15:0] lfsr = 16'hACE1;
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      lfsr      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      out_ready = lfsr[0];
    end else begin
      out_ready = 1'b1;
    end
  end

  typedef struct {
    logic [WW-1:0] d;
    logic          sop;
    logic          eop;
    logic [HW-1:0] h;
  } exp_t;

  exp_t          exp_q [$];
  logic [AW-1:0] done_q [$];
  int checks = 0;
  int fails  = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int rdreq_cnt = 0;
  int rdreq_bad = 0;

  function automatic logic [WW-1:0] word_of(input int a, input int k);
    return WW'(a * 8 + k + 1);
  endfunction

  // Monitor: pops expected words on every accept, checks hold-under-stall and completions
  exp_t          e;
  logic          held = 1'b0;
  logic [WW-1:0] hd;
  logic          hs;
  logic          he;
  logic [AW-1:0] da;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (hdr_rdreq) begin
        rdreq_cnt++;
        if (hdr_empty) rdreq_bad++;
      end
      if (held) begin
        checks++;
        if (!out_valid || out_data !== hd || out_sop !== hs || out_eop !== he) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b d=%h sop=%0b eop=%0b, need v=1 d=%h sop=%0b eop=%0b",
                   out_valid, out_data, out_sop, out_eop, hd, hs, he);
        end
      end
      if (out_valid && out_ready) begin
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word: got d=%h with no word expected", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop || out_hdr !== e.h) begin
            fails++;
            $display("FAIL word: got d=%h sop=%0b eop=%0b hdr=%h, need d=%h sop=%0b eop=%0b hdr=%h",
                     out_data, out_sop, out_eop, out_hdr, e.d, e.sop, e.eop, e.h);
          end
        end
      end
      held = out_valid && !out_ready;
      hd = out_data;
      hs = out_sop;
      he = out_eop;
      if (rd_done) begin
        done_cnt++;
        checks++;
        if (done_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got addr=%0d with none expected", rd_done_addr);
        end else begin
          da = done_q.pop_front();
          if (rd_done_addr !== da) begin
            fails++;
            $display("FAIL done_addr: got %0d, need %0d", rd_done_addr, da);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, need %0h", name, act, req);
    end
  endtask

  // Queue one header and push its expected words and completion address
  task automatic send(input int tag, input int start, input int stop);
    logic [HW-1:0] h;
    logic [AW-1:0] a;
    bit            first;
    h = '0;
    h[AW-1:0]      = AW'(start);
    h[2*AW-1:AW]   = AW'(stop);
    h[HW-1:2*AW]   = {8'(tag), 76'h0_A5A5_0F0F_3C3C_C3C3};
    a = AW'(start);
    first = 1'b1;
    for (int n = 0; n < 1024; n++) begin
      for (int k = 0; k < 4; k++)
        exp_q.push_back('{word_of(int'(a), k), first && k == 0, (a == AW'(stop)) && k == 3, h});
      first = 1'b0;
      if (a == AW'(stop)) break;
      a = AW'(a + AW'(1));
    end
    done_q.push_back(AW'(stop));
    hdr_mem[wr_ptr[3:0]] = h;
    wr_ptr++;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_in_budget", HW'(n < budget), HW'(1));
  endtask

  // Cycles from the push to first out_valid and to rd_done, with ready held high
  task automatic timing(input string name, input int lines);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_first_valid_cycles"}, HW'(n), HW'(5));
    while (!rd_done && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_done_cycles"}, HW'(n), HW'(6 * lines + 3));
  endtask

  int a0, d0, r0, n;
  initial begin
    rst_n = 1'b0;
    for (int a = 0; a < 1024; a++)
      wmem[a] = {word_of(a, 3), word_of(a, 2), word_of(a, 1), word_of(a, 0), 1'b0};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hdr_rdreq", HW'(hdr_rdreq), '0);
    chk("rst_out_valid", HW'(out_valid), '0);
    chk("rst_out_data", HW'(out_data), '0);
    chk("rst_out_hdr", out_hdr, '0);
    chk("rst_rd_done", HW'({rd_done, rd_done_addr, out_sop, out_eop, eoe_err}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two lines, start=5 stop=6
    wmem[6][0] = 1'b1;
    a0 = acc_cnt;
    @(posedge clk); #2;
    send(1, 5, 6);
    timing("two_line", 2);
    wait_drain(100);
    chk("two_line_words", HW'(acc_cnt - a0), HW'(8));

    // Address wrap 1022 -> 1
    wmem[1][0] = 1'b1;
    a0 = acc_cnt;
    @(posedge clk); #2;
    send(2, 1022, 1);
    timing("wrap", 4);
    wait_drain(100);
    chk("wrap_words", HW'(acc_cnt - a0), HW'(16));

    // Backpressure
    wmem[103][0] = 1'b1;
    a0 = acc_cnt;
    bp_mode = 1'b1;
    @(posedge clk); #2;
    send(3, 100, 103);
    wait_drain(600);
    bp_mode = 1'b0;
    chk("bp_words", HW'(acc_cnt - a0), HW'(16));

    // Back-to-back single-line headers
    wmem[200][0] = 1'b1;
    wmem[210][0] = 1'b1;
    wmem[220][0] = 1'b1;
    repeat (3) @(negedge clk);
    r0 = rdreq_cnt;
    d0 = done_cnt;
    @(posedge clk); #2;
    send(4, 200, 200);
    send(5, 210, 210);
    send(6, 220, 220);
    wait_drain(300);
    repeat (3) @(negedge clk);
    chk("b2b_rdreq_pulses", HW'(rdreq_cnt - r0), HW'(3));
    chk("b2b_done_pulses", HW'(done_cnt - d0), HW'(3));

    // Reset while word 2 is presented
    wmem[301][0] = 1'b1;
    a0 = acc_cnt;
    @(posedge clk); #2;
    send(7, 300, 301);
    n = 0;
    while (acc_cnt < a0 + 2 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("reset_reach_word2", HW'(n < 100), HW'(1));
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", HW'(out_valid), '0);
    chk("async_out_data", HW'(out_data), '0);
    chk("async_out_hdr", out_hdr, '0);
    chk("async_misc", HW'({out_sop, out_eop, rd_done, hdr_rdreq, eoe_err}), '0);
    chk("async_addrs", HW'({wvb_rd_addr, rd_done_addr}), '0);
    exp_q.delete();
    done_q.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("no_done_after_abort", HW'(done_cnt - d0), '0);
    wmem[311][0] = 1'b1;
    a0 = acc_cnt;
    @(posedge clk); #2;
    send(8, 310, 311);
    wait_drain(100);
    chk("post_reset_words", HW'(acc_cnt - a0), HW'(8));

    // EOE consistency: stop line 400 has EOE clear
    chk("eoe_clean", HW'(eoe_err), '0);
    @(posedge clk); #2;
    send(9, 400, 400);
    wait_drain(100);
    chk("eoe_flag", HW'(eoe_err), HW'(EOE_EXP));
    wmem[410][0] = 1'b1;
    @(posedge clk); #2;
    send(10, 410, 410);
    wait_drain(100);
    chk("eoe_sticky", HW'(eoe_err), HW'(EOE_EXP));

    chk("rdreq_while_empty", HW'(rdreq_bad), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
